sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the team's dual-clock FIFO.
- Configurable width and depth.
- Programmable almost-full and almost-empty thresholds.
- Exposes an occupancy count and sticky overflow/underflow error flags that software or the bench can clear.
- Used as the generic buffering element between same-clock stages; protocol misuse is flagged by hardware, so assertions are not the only check.

Parameters:
- DataSize, 8, data word width in bits (>=1).
- AddrSize, 3, address width; Depth = 2**AddrSize entries (>=1).
- AlmostFullThresh, 6, almost_full asserted when Count >= AlmostFullThresh (1..Depth).
- AlmostEmptyThresh, 1, almost_empty asserted when Count <= AlmostEmptyThresh (0..Depth-1).

Ports:
- Clk  input  1  single clock, all state on posedge.
- Resetn  input  1  asynchronous active-low reset, synchronously deasserted by the system.
- Push  input  1  write request.
- Pop  input  1  read request.
- DataIn  input  DataSize  write data, sampled on accepted Push.
- ClearErr  input  1  synchronous clear of overflow/underflow.
- DataOut  output  DataSize  registered read data.
- full  output  1  Count == Depth.
- empty  output  1  Count == 0.
- almost_full  output  1  Count >= AlmostFullThresh.
- almost_empty  output  1  Count <= AlmostEmptyThresh.
- Count  output  AddrSize+1  current occupancy, 0..Depth.
- overflow  output  1  sticky: a Push was rejected.
- underflow  output  1  sticky: a Pop was rejected.

Behaviour:
- Reset (Resetn low, asynchronous):
  - WritePtr = ReadPtr = 0, Count = 0, DataOut = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0.
  - Memory contents are not reset.
- Pointers: WritePtr and ReadPtr are AddrSize+1 bits. The low AddrSize bits index the array; the MSB is the wrap bit. Pointers wrap naturally modulo 2*Depth.
- Accept rules, evaluated on the current-cycle flags:
  - push_ok = Push & (!full | Pop).
  - pop_ok = Pop & !empty.
- Full with Push and Pop together: both accepted. The head is read and the new word is written to the tail slot. Count stays Depth and full stays 1.
- Empty with Push and Pop together: Pop is rejected and underflow is set. Push is accepted, so Count becomes 1. The data is not bypassed.
- Write: on push_ok, mem[WritePtr] <= DataIn and WritePtr increments.
- Read: on pop_ok, DataOut <= mem[ReadPtr] and ReadPtr increments.
  - Latency is one Clk: data appears the cycle after Pop is accepted.
  - DataOut holds its value when there is no accepted pop.
- Count: Count + push_ok - pop_ok, kept as a register. It must always equal WritePtr - ReadPtr (modulo 2*Depth).
- Flags: full, empty, almost_full and almost_empty are decoded combinationally from the registered Count only, with no combinational path from Push or Pop. They are therefore valid in the cycle after the operation.
- Errors:
  - overflow <= 1 on Push & full & !Pop.
  - underflow <= 1 on Pop & empty.
  - ClearErr clears both. If a new error occurs in the same cycle as ClearErr, the set wins.
- Rejected operations change no pointer, Count, memory or DataOut.
- Parameter check: elaboration error if thresholds are out of range.

Decomposition:
- Package sync_fifo_pkg holds:
  - function ptr_width(addr) returning addr+1.
  - function depth(addr) returning 2**addr.
  - typedef for the count type.
- Sub-module sync_fifo_mem: Depth x DataSize register array with write port and registered read port (re, raddr, rdata).
- Pointers, Count, flags and error logic stay in the top.

Test Plan (DataSize=8, AddrSize=3, AlmostFullThresh=6, AlmostEmptyThresh=1):
- Reset, then idle 3 cycles -> empty=1, almost_empty=1, full=0, Count=0, DataOut=0x00, overflow=underflow=0.
- Push 0x01..0x08 back-to-back, then Pop 8 times -> Count steps 1..8; almost_empty drops at Count=2; almost_full rises at Count=6; full=1 at 8. DataOut shows 0x01..0x08 each one cycle after its Pop. empty=1 at the end.
- Fill to 8, then Push 0xAA alone -> overflow=1, Count=8, 0xAA never read. Then Push 0xBB with Pop together -> Count=8, full=1, and 0xBB is the 8th word read after the remaining 0x02..0x08.
- Empty FIFO, Pop with Push 0x55 together -> underflow=1, Count=1. The next Pop returns 0x55 one cycle later. Then ClearErr -> underflow=0.
- Push 20 and pop 20 interleaved at random with data = index -> pointers wrap twice, all data in order, Count always equals pushes minus pops.
- Assert Resetn low mid-stream at Count=5 -> all outputs return to reset values immediately without waiting for a Clk edge. After release, the first Push/Pop of 0x77 returns 0x77.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared helpers for the single-clock FIFO slice.
//   ptr_width(addr) : width of a read/write pointer (index bits + wrap bit)
//   depth(addr)     : number of storage entries for a given address width
//   count_t         : occupancy type for the default (AddrSize = 3) build.
//                     Instances with another AddrSize derive their own
//                     occupancy width from ptr_width().
package sync_fifo_pkg;

  localparam int DefaultAddrSize = 3;

  function automatic int ptr_width(input int addr);
    return addr + 1;
  endfunction

  function automatic int depth(input int addr);
    return 2 ** addr;
  endfunction

  typedef logic [DefaultAddrSize:0] count_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem
//   Depth x DataSize storage array with one write port and one registered
//   read port. The array itself is never reset; only the read register is.
//   Ports:
//     Clk    : clock, all state on posedge
//     Resetn : asynchronous active-low reset of the read register
//     we     : write enable
//     waddr  : write address
//     wdata  : write data
//     re     : read enable (rdata loads mem[raddr] on the next edge)
//     raddr  : read address
//     rdata  : registered read data, holds when re is low
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DataSize = 8,
  parameter int AddrSize = 3
) (
  input  logic                Clk,
  input  logic                Resetn,
  input  logic                we,
  input  logic [AddrSize-1:0] waddr,
  input  logic [DataSize-1:0] wdata,
  input  logic                re,
  input  logic [AddrSize-1:0] raddr,
  output logic [DataSize-1:0] rdata
);

  localparam int Depth = depth(AddrSize);

  logic [DataSize-1:0] mem [Depth];

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // When raddr == waddr in the same cycle (full FIFO, push and pop together)
  // the read sees the old word: the head leaves before the tail overwrites it.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock FIFO with programmable almost-full/almost-empty thresholds,
//   an occupancy count and sticky overflow/underflow flags.
//   Ports:
//     Clk          : clock, all state on posedge
//     Resetn       : asynchronous active-low reset
//     Push, Pop    : write / read requests
//     DataIn       : write data, captured on an accepted Push
//     ClearErr     : synchronous clear of overflow/underflow (a new error wins)
//     DataOut      : registered read data, valid the cycle after an accepted Pop
//     full, empty  : Count == Depth / Count == 0
//     almost_full  : Count >= AlmostFullThresh
//     almost_empty : Count <= AlmostEmptyThresh
//     Count        : occupancy 0..Depth
//     overflow     : sticky, a Push was rejected
//     underflow    : sticky, a Pop was rejected
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DataSize          = 8,
  parameter int AddrSize          = 3,
  parameter int AlmostFullThresh  = 6,
  parameter int AlmostEmptyThresh = 1
) (
  input  logic                  Clk,
  input  logic                  Resetn,
  input  logic                  Push,
  input  logic                  Pop,
  input  logic [DataSize-1:0]   DataIn,
  input  logic                  ClearErr,
  output logic [DataSize-1:0]   DataOut,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AddrSize:0]     Count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PtrW  = ptr_width(AddrSize);
  localparam int Depth = depth(AddrSize);

  localparam logic [PtrW-1:0] DepthC = PtrW'(Depth);
  localparam logic [PtrW-1:0] AfC    = PtrW'(AlmostFullThresh);
  localparam logic [PtrW-1:0] AeC    = PtrW'(AlmostEmptyThresh);
  localparam logic [PtrW-1:0] OneC   = PtrW'(1);

  if (DataSize < 1) begin : g_chk_data
    $error("sync_fifo_param: DataSize must be >= 1");
  end
  if (AddrSize < 1) begin : g_chk_addr
    $error("sync_fifo_param: AddrSize must be >= 1");
  end
  if (AlmostFullThresh < 1 || AlmostFullThresh > Depth) begin : g_chk_af
    $error("sync_fifo_param: AlmostFullThresh must be in 1..Depth");
  end
  if (AlmostEmptyThresh < 0 || AlmostEmptyThresh > Depth - 1) begin : g_chk_ae
    $error("sync_fifo_param: AlmostEmptyThresh must be in 0..Depth-1");
  end

  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            push_ok;
  logic            pop_ok;
  logic            ovf_set;
  logic            udf_set;

  // Status flags come only from the registered Count, so they never depend
  // combinationally on this cycle's Push/Pop.
  assign full         = (Count == DepthC);
  assign empty        = (Count == '0);
  assign almost_full  = (Count >= AfC);
  assign almost_empty = (Count <= AeC);

  // A push into a full FIFO is still accepted when a pop frees the head slot
  // in the same cycle. A pop on empty is always rejected; no bypass of DataIn.
  assign push_ok = Push & (~full | Pop);
  assign pop_ok  = Pop & ~empty;

  assign ovf_set = Push & full & ~Pop;
  assign udf_set = Pop & empty;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + OneC;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + OneC;
      end
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      Count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   Count <= Count + OneC;
        2'b01:   Count <= Count - OneC;
        default: Count <= Count;
      endcase
    end
  end

  // Sticky error flags: set has priority over ClearErr in the same cycle.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ClearErr) begin
        overflow <= 1'b0;
      end
      if (udf_set) begin
        underflow <= 1'b1;
      end else if (ClearErr) begin
        underflow <= 1'b0;
      end
    end
  end

  // The occupancy register is kept alongside the pointers; both views of the
  // fill level must agree at every edge.
  always @(posedge Clk) begin
    if (Resetn) begin
      assert (Count == PtrW'(wr_ptr - rd_ptr))
        else $error("sync_fifo_param: Count disagrees with pointer difference");
    end
  end

  sync_fifo_mem #(
    .DataSize (DataSize),
    .AddrSize (AddrSize)
  ) u_mem (
    .Clk    (Clk),
    .Resetn (Resetn),
    .we     (push_ok),
    .waddr  (wr_ptr[AddrSize-1:0]),
    .wdata  (DataIn),
    .re     (pop_ok),
    .raddr  (rd_ptr[AddrSize-1:0]),
    .rdata  (DataOut)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  logic       Clk      = 1'b0;
  logic       Resetn   = 1'b0;
  logic       Push     = 1'b0;
  logic       Pop      = 1'b0;
  logic [7:0] DataIn   = 8'h00;
  logic       ClearErr = 1'b0;
  logic [7:0] DataOut;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] Count;
  logic       overflow;
  logic       underflow;

  always #5 Clk = ~Clk;

  sync_fifo_param #(
    .DataSize          (8),
    .AddrSize          (3),
    .AlmostFullThresh  (6),
    .AlmostEmptyThresh (1)
  ) dut (
    .Clk          (Clk),
    .Resetn       (Resetn),
    .Push         (Push),
    .Pop          (Pop),
    .DataIn       (DataIn),
    .ClearErr     (ClearErr),
    .DataOut      (DataOut),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .Count        (Count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: contents queue, expected read-data queue, sticky flags.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_dout = 8'h00;
  bit         m_ov   = 1'b0;
  bit         m_uf   = 1'b0;

  typedef struct {
    bit         push;
    bit         pop;
    logic [7:0] din;
    logic [3:0] cnt;
    bit         fl;
    bit         em;
    bit         af;
    bit         ae;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_dout = 8'h00;
    m_ov   = 1'b0;
    m_uf   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    int n;
    n = mq.size();
    if (exp_q.size() > 0) m_dout = exp_q.pop_front();
    chk({tag, ".count"},        32'(Count),        32'(n));
    chk({tag, ".full"},         32'(full),         32'(n == 8));
    chk({tag, ".empty"},        32'(empty),        32'(n == 0));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(n >= 6));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 1));
    chk({tag, ".overflow"},     32'(overflow),     32'(m_ov));
    chk({tag, ".underflow"},    32'(underflow),    32'(m_uf));
    chk({tag, ".dataout"},      32'(DataOut),      32'(m_dout));
  endtask

  // One clock of stimulus: drive on the falling edge, update the model with
  // the accept rules seen from the outside, check #1 after the rising edge.
  task automatic cycle(input string tag, input bit push, input bit pop,
                       input logic [7:0] din, input bit clr);
    bit m_full;
    bit m_empty;
    m_full  = (mq.size() == 8);
    m_empty = (mq.size() == 0);
    @(negedge Clk);
    Push = push; Pop = pop; DataIn = din; ClearErr = clr;
    if (pop && !m_empty) exp_q.push_back(mq.pop_front());
    if (push && (!m_full || pop)) mq.push_back(din);
    if (push && m_full && !pop) m_ov = 1'b1;
    else if (clr)               m_ov = 1'b0;
    if (pop && m_empty)         m_uf = 1'b1;
    else if (clr)               m_uf = 1'b0;
    @(posedge Clk);
    #1;
    Push = 1'b0; Pop = 1'b0; ClearErr = 1'b0;
    check_state(tag);
  endtask

  initial begin
    int pushes;
    int pops;
    int iter;

    //            push pop din    cnt fl em af ae dout
    tbl = '{
      '{1'b1, 1'b0, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00},
      '{1'b1, 1'b0, 8'h02, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b0, 8'h03, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b0, 8'h04, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b0, 8'h05, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b0, 8'h06, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b1, 1'b0, 8'h07, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b1, 1'b0, 8'h08, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 8'h00, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01},
      '{1'b0, 1'b1, 8'h00, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02},
      '{1'b0, 1'b1, 8'h00, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03},
      '{1'b0, 1'b1, 8'h00, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04},
      '{1'b0, 1'b1, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05},
      '{1'b0, 1'b1, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h06},
      '{1'b0, 1'b1, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07},
      '{1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h08}
    };

    // Reset and idle
    model_reset();
    repeat (2) @(negedge Clk);
    Resetn = 1'b1;
    for (int i = 0; i < 3; i++) cycle("idle", 1'b0, 1'b0, 8'h00, 1'b0);

    // Fill and drain with fixed expected values
    for (int i = 0; i < 16; i++) begin
      cycle("tbl", tbl[i].push, tbl[i].pop, tbl[i].din, 1'b0);
      chk($sformatf("tbl[%0d].count", i), 32'(Count),        32'(tbl[i].cnt));
      chk($sformatf("tbl[%0d].full", i),  32'(full),         32'(tbl[i].fl));
      chk($sformatf("tbl[%0d].empty", i), 32'(empty),        32'(tbl[i].em));
      chk($sformatf("tbl[%0d].af", i),    32'(almost_full),  32'(tbl[i].af));
      chk($sformatf("tbl[%0d].ae", i),    32'(almost_empty), 32'(tbl[i].ae));
      chk($sformatf("tbl[%0d].dout", i),  32'(DataOut),      32'(tbl[i].dout));
    end

    // Overflow on full, then push+pop together while full
    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 1'b0, 8'(i), 1'b0);
    cycle("ovf_push", 1'b1, 1'b0, 8'hAA, 1'b0);
    chk("ovf.flag",  32'(overflow), 32'd1);
    chk("ovf.count", 32'(Count),    32'd8);
    cycle("full_pushpop", 1'b1, 1'b1, 8'hBB, 1'b0);
    chk("full_pushpop.dout", 32'(DataOut), 32'h01);
    chk("full_pushpop.full", 32'(full),    32'd1);
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain.last_is_bb", 32'(DataOut), 32'hBB);
    cycle("clr_ovf", 1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_ovf.flag", 32'(overflow), 32'd0);

    // Underflow with push on empty, no bypass
    cycle("empty_pushpop", 1'b1, 1'b1, 8'h55, 1'b0);
    chk("udf.flag",  32'(underflow), 32'd1);
    chk("udf.count", 32'(Count),     32'd1);
    chk("udf.nobypass", 32'(DataOut), 32'hBB);
    cycle("pop55", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("pop55.dout", 32'(DataOut), 32'h55);
    cycle("clr_udf", 1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_udf.flag", 32'(underflow), 32'd0);

    // Error set wins over a simultaneous clear
    cycle("set_vs_clr", 1'b0, 1'b1, 8'h00, 1'b1);
    chk("set_vs_clr.flag", 32'(underflow), 32'd1);
    cycle("clr_again", 1'b0, 1'b0, 8'h00, 1'b1);

    // Random interleave of 20 pushes and 20 pops, data = index
    pushes = 0;
    pops   = 0;
    iter   = 0;
    while ((pushes < 20 || pops < 20) && iter < 1000) begin
      bit dp;
      bit dq;
      dp = (pushes < 20) && (mq.size() < 8) && ($urandom_range(0, 1) == 1);
      dq = (pops < 20) && (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      if (dp || dq) begin
        cycle("rand", dp, dq, 8'(pushes), 1'b0);
        if (dp) pushes++;
        if (dq) pops++;
        chk("rand.count_vs_ops", 32'(Count), 32'(pushes - pops));
      end
      iter++;
    end
    chk("rand.completed", 32'(pushes + pops), 32'd40);
    chk("rand.last_data", 32'(DataOut), 32'd19);

    // Asynchronous reset mid-stream at Count=5 with underflow set
    cycle("pre_udf", 1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 1'b0, 8'h30 + 8'(i), 1'b0);
    chk("pre_rst.count", 32'(Count), 32'd5);
    #2;
    Resetn = 1'b0;
    #1;
    model_reset();
    chk("async_rst.count",     32'(Count),        32'd0);
    chk("async_rst.empty",     32'(empty),        32'd1);
    chk("async_rst.full",      32'(full),         32'd0);
    chk("async_rst.af",        32'(almost_full),  32'd0);
    chk("async_rst.ae",        32'(almost_empty), 32'd1);
    chk("async_rst.dout",      32'(DataOut),      32'd0);
    chk("async_rst.overflow",  32'(overflow),     32'd0);
    chk("async_rst.underflow", 32'(underflow),    32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Resetn = 1'b1;
    cycle("post_rst_push", 1'b1, 1'b0, 8'h77, 1'b0);
    cycle("post_rst_pop",  1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_rst.dout", 32'(DataOut), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
